clint_timer: RTL and testbench

CLINT_TIMER -- requirements
Module: clint_timer

---
 rtl/clint_timer.sv | 120 ++++++++++++
 tb/tb_clint_timer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - machine timer and software interrupt block with a single-request register bus
module clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        timer_interrupt,
    output logic        software_interrupt
);
    localparam logic [15:0] ADDR_MSIP   = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI = 16'h4004;
    localparam logic [15:0] ADDR_MT_LO  = 16'hBFF8;
    localparam logic [15:0] ADDR_MT_HI  = 16'hBFFC;
    localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t      state;
    logic [31:0] msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [15:0] prescaler;
    logic        accept;
    logic        wr;
    logic        tick;
    logic        wr_mtime;
    logic [31:0] rd_data;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    assign accept   = (state == ST_IDLE) && bus_valid;
    assign wr       = accept && bus_we;
    assign tick     = (prescaler == TICK_LAST);
    // An mtime write with no byte enables changes nothing, so it does not steal the tick.
    assign wr_mtime = wr && ((bus_addr == ADDR_MT_LO) || (bus_addr == ADDR_MT_HI)) && (bus_wstrb != 4'b0000);

    assign software_interrupt = msip[0];

    always_comb begin
        rd_data = 32'h0;
        case (bus_addr)
            ADDR_MSIP:   rd_data = msip;
            ADDR_CMP_LO: rd_data = mtimecmp[31:0];
            ADDR_CMP_HI: rd_data = mtimecmp[63:32];
            ADDR_MT_LO:  rd_data = mtime[31:0];
            ADDR_MT_HI:  rd_data = mtime[63:32];
            default:     rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            msip            <= 32'h0;
            mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime           <= 64'h0;
            prescaler       <= 16'h0;
            bus_ready       <= 1'b0;
            bus_rdata       <= 32'h0;
            timer_interrupt <= 1'b0;
        end else begin
            prescaler       <= tick ? 16'h0 : prescaler + 16'd1;
            timer_interrupt <= (mtime >= mtimecmp);

            // A bus write to either half wins over the tick; the other half holds.
            if (wr_mtime) begin
                if (bus_addr == ADDR_MT_LO)
                    mtime[31:0]  <= merge_bytes(mtime[31:0], bus_wdata, bus_wstrb);
                else
                    mtime[63:32] <= merge_bytes(mtime[63:32], bus_wdata, bus_wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr && (bus_addr == ADDR_MSIP) && bus_wstrb[0])
                msip <= {31'h0, bus_wdata[0]};
            if (wr && (bus_addr == ADDR_CMP_LO))
                mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus_wdata, bus_wstrb);
            if (wr && (bus_addr == ADDR_CMP_HI))
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_wdata, bus_wstrb);

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RESP;
                        bus_ready <= 1'b1;
                        bus_rdata <= rd_data;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    bus_ready <= 1'b0;
                    bus_rdata <= 32'h0;
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_ready <= 1'b0;
                    bus_rdata <= 32'h0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - scoreboard bench for clint_timer at TICK_DIV 1 and 4
module tb_clint_timer;
    logic        clock = 1'b0;
    logic        reset;
    logic        bus_valid;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;

    logic        ready0, ready1;
    logic [31:0] rdata0, rdata1;
    logic        ti0, ti1, si0, si1;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    always #5 clock = ~clock;

    clint_timer #(.TICK_DIV(1)) u0 (
        .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(ready0), .bus_rdata(rdata0),
        .timer_interrupt(ti0), .software_interrupt(si0)
    );

    clint_timer #(.TICK_DIV(4)) u1 (
        .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(ready1), .bus_rdata(rdata1),
        .timer_interrupt(ti1), .software_interrupt(si1)
    );

    // Reference model: architectural registers plus a cycle count since reset.
    int unsigned div_k [2] = '{1, 4};
    longint unsigned m_time [2];
    longint unsigned m_cmp  [2];
    int unsigned     m_cyc  [2];
    logic            m_msip [2];
    logic            m_tirq [2];
    logic            m_busy [2];
    logic            m_rdy  [2];
    logic [31:0]     q0 [$];
    logic [31:0]     q1 [$];

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [15:0] a);
        case (a)
            16'h0000: return {31'h0, m_msip[k]};
            16'h4000: return m_cmp[k][31:0];
            16'h4004: return m_cmp[k][63:32];
            16'hBFF8: return m_time[k][31:0];
            16'hBFFC: return m_time[k][63:32];
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_time[k] = 0;
                m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
                m_cyc[k]  = 0;
                m_msip[k] = 1'b0;
                m_tirq[k] = 1'b0;
                m_busy[k] = 1'b0;
                m_rdy[k]  = 1'b0;
                if (k == 0) q0.delete(); else q1.delete();
            end else begin
                logic        irq_next;
                logic        do_tick;
                logic        time_written;
                logic [31:0] mask;
                irq_next     = (m_time[k] >= m_cmp[k]);
                do_tick      = (m_cyc[k] % div_k[k]) == div_k[k] - 1;
                m_cyc[k]     = m_cyc[k] + 1;
                time_written = 1'b0;
                m_rdy[k]     = 1'b0;
                if (!m_busy[k] && bus_valid) begin
                    m_busy[k] = 1'b1;
                    m_rdy[k]  = 1'b1;
                    if (k == 0) q0.push_back(model_read(0, bus_addr));
                    else        q1.push_back(model_read(1, bus_addr));
                    if (bus_we) begin
                        mask = strb_mask(bus_wstrb);
                        case (bus_addr)
                            16'h0000: if (bus_wstrb[0]) m_msip[k] = bus_wdata[0];
                            16'h4000: m_cmp[k][31:0]  = (m_cmp[k][31:0]  & ~mask) | (bus_wdata & mask);
                            16'h4004: m_cmp[k][63:32] = (m_cmp[k][63:32] & ~mask) | (bus_wdata & mask);
                            16'hBFF8: begin
                                m_time[k][31:0] = (m_time[k][31:0] & ~mask) | (bus_wdata & mask);
                                time_written = (bus_wstrb != 0);
                            end
                            16'hBFFC: begin
                                m_time[k][63:32] = (m_time[k][63:32] & ~mask) | (bus_wdata & mask);
                                time_written = (bus_wstrb != 0);
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    m_busy[k] = 1'b0;
                end
                if (!time_written && do_tick) m_time[k] = m_time[k] + 1;
                m_tirq[k] = irq_next;
            end
        end
    end

    task automatic mon(input int k, input logic rdy, input logic [31:0] rd,
                       input logic ti, input logic si);
        logic [31:0] exp_rd;
        n_vec++;
        if (rdy !== m_rdy[k]) begin
            n_err++;
            $display("FAIL ready[%0d] t=%0t got %b want %b", k, $time, rdy, m_rdy[k]);
        end
        if (rdy === 1'b1) begin
            n_vec++;
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                n_err++;
                $display("FAIL rdata[%0d] t=%0t got %h want <no pending request>", k, $time, rd);
            end else begin
                exp_rd = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (rd !== exp_rd) begin
                    n_err++;
                    $display("FAIL rdata[%0d] t=%0t got %h want %h", k, $time, rd, exp_rd);
                end
            end
        end else begin
            n_vec++;
            if (rd !== 32'h0) begin
                n_err++;
                $display("FAIL rdata_idle[%0d] t=%0t got %h want 0", k, $time, rd);
            end
        end
        n_vec++;
        if (ti !== m_tirq[k]) begin
            n_err++;
            $display("FAIL timer_irq[%0d] t=%0t got %b want %b", k, $time, ti, m_tirq[k]);
        end
        n_vec++;
        if (si !== m_msip[k]) begin
            n_err++;
            $display("FAIL sw_irq[%0d] t=%0t got %b want %b", k, $time, si, m_msip[k]);
        end
    endtask

    always @(negedge clock) begin
        if (ready0 === 1'b1) pulse_cnt++;
        mon(0, ready0, rdata0, ti0, si0);
        mon(1, ready1, rdata1, ti1, si1);
    end

    task automatic idle(input int n);
        bus_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic req(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
        bus_wstrb = s;
        @(negedge clock);
        bus_valid = 1'b0;
        @(negedge clock);
    endtask

    logic [15:0] addr_tab [6] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234};

    initial begin
        int c0;
        logic [15:0] a;
        logic [3:0]  s;
        reset = 1'b1; bus_valid = 1'b0; bus_we = 1'b0;
        bus_addr = 16'h0; bus_wdata = 32'h0; bus_wstrb = 4'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        idle(10);
        req(1'b0, 16'hBFF8, 32'h0, 4'h0);

        req(1'b1, 16'h4000, 32'h20, 4'hF);
        req(1'b1, 16'h4004, 32'h0, 4'hF);
        idle(20);
        req(1'b1, 16'h4004, 32'hFFFF_FFFF, 4'hF);
        idle(3);

        req(1'b1, 16'h0000, 32'h1, 4'hF);
        req(1'b1, 16'h0000, 32'h0, 4'hF);
        req(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
        req(1'b0, 16'h0000, 32'h0, 4'h0);

        req(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        req(1'b1, 16'hBFFC, 32'h0, 4'hF);
        idle(3);
        req(1'b0, 16'hBFF8, 32'h0, 4'h0);
        req(1'b0, 16'hBFFC, 32'h0, 4'h0);

        req(1'b1, 16'h4004, 32'h0000_AB00, 4'b0010);
        req(1'b0, 16'h4004, 32'h0, 4'h0);
        req(1'b0, 16'h4000, 32'h0, 4'h0);

        c0 = pulse_cnt;
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 16'h1234; bus_wstrb = 4'h0;
        repeat (6) @(negedge clock);
        idle(2);
        n_vec++;
        if (pulse_cnt - c0 != 3) begin
            n_err++;
            $display("FAIL b2b_pulses got %0d want 3", pulse_cnt - c0);
        end

        // Request presented in the reset cycle is dropped with no response.
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 16'h0000; bus_wdata = 32'h1; bus_wstrb = 4'hF;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus_valid = 1'b0;
        idle(2);
        req(1'b0, 16'h0000, 32'h0, 4'h0);

        // Reset landing while the response is showing.
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 16'hBFF8;
        @(negedge clock);
        bus_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 300; i++) begin
            a = addr_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            s = 4'($urandom);
            if ((a == 16'hBFF8 || a == 16'hBFFC) && s == 4'h0) s = 4'hF;
            req(1'($urandom), a, $urandom, s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        idle(3);

        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL pending_responses got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
